// File: rtl/sctag_cpx_pkg.sv
// Shared types and defaults for the SCTAG-to-CPX output queue.
package sctag_cpx_pkg;

   localparam int CPX_WIDTH_DEF = 145;
   localparam int OQ_DEPTH_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } oq_state_e;

   typedef struct packed {
      logic [CPX_WIDTH_DEF-1:0] pkt;
      logic [7:0]               dest;
      logic                     atom;
   } oq_entry_t;

endpackage

// File: rtl/sctag_cpx_oq_fifo.sv
// Output-queue storage: circular buffer with registered occupancy, full flag
// and a one-cycle protocol-error pulse for pushes that arrive while full.
module sctag_cpx_oq_fifo #(
   parameter int  ENTRY_W = 154,
   parameter int  DEPTH   = 4,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic               rclk_i,
   input  logic               arst_i,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] wr_data_i,
   input  logic               pop_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic [ENTRY_W-1:0] next_o,
   output logic [CW-1:0]      cnt_o,
   output logic               full_o,
   output logic               perr_o
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               full_q, perr_q, accept;

   // A push is only admitted against the registered full flag, so a pop in
   // the same cycle never makes room for it.
   assign accept     = push_i & ~full_q;
   assign rd_ptr_nxt = rd_ptr_q + AW'(1);

   always_ff @(posedge rclk_i) begin
      if (accept) mem[wr_ptr_q] <= wr_data_i;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, pop_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge rclk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_nxt;
         cnt_q  <= cnt_d;
         full_q <= (cnt_d == CW'(DEPTH));
         perr_q <= push_i & full_q;
      end
   end

   assign head_o = mem[rd_ptr_q];
   assign next_o = mem[rd_ptr_nxt];
   assign cnt_o  = cnt_q;
   assign full_o = full_q;
   assign perr_o = perr_q;

endmodule

// File: rtl/sctag_cpx_oq.sv
// SCTAG-to-CPX output queue: request/wait/grant handshake toward the CPX
// repeater. Define SCTAG_CPX_OQ_ATOM_EN to enable atomic-pair handling.
module sctag_cpx_oq
   import sctag_cpx_pkg::*;
#(
   parameter int CPX_WIDTH = CPX_WIDTH_DEF,
   parameter int OQ_DEPTH  = OQ_DEPTH_DEF
) (
   input  logic                      rclk,
   input  logic                      arst,
   input  logic                      oq_push,
   input  logic [CPX_WIDTH-1:0]      oq_pkt,
   input  logic [7:0]                oq_dest,
   input  logic                      oq_atom,
   output logic                      oq_full,
   output logic [$clog2(OQ_DEPTH):0] oq_cnt,
   output logic                      oq_perr,
   output logic [7:0]                sctag_cpx_req_cq,
   output logic                      sctag_cpx_atom_cq,
   output logic [CPX_WIDTH-1:0]      sctag_cpx_data_ca,
   input  logic [7:0]                cpx_sctag_grant_cx
);

   localparam int CW      = $clog2(OQ_DEPTH) + 1;
   localparam int ENTRY_W = CPX_WIDTH + 9;

   oq_state_e            state_q;
   logic [7:0]           req_q;
   logic                 atom_q;
   logic [CPX_WIDTH-1:0] data_q;

   logic [ENTRY_W-1:0]   wr_entry, head, next_entry, nxt_sel;
   logic                 wr_atom, push_acc, grant_hit, more_pkt, multi;

`ifdef SCTAG_CPX_OQ_ATOM_EN
   assign wr_atom  = oq_atom;
   // The second half of an atomic pair may still be in flight as this
   // cycle's push; it is forwarded so the FSM can go straight to REQ.
   assign more_pkt = multi | (head[0] & push_acc);
`else
   logic unused_atom;
   assign unused_atom = oq_atom;
   assign wr_atom     = 1'b0;
   assign more_pkt    = multi;
`endif

   assign wr_entry  = {oq_pkt, oq_dest, wr_atom};
   assign push_acc  = oq_push & ~oq_full;
   assign multi     = (oq_cnt > CW'(1));
   assign nxt_sel   = multi ? next_entry : wr_entry;
   assign grant_hit = (state_q == ST_WAIT) && ((cpx_sctag_grant_cx & head[8:1]) != 8'h00);

   sctag_cpx_oq_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (OQ_DEPTH)
   ) u_fifo (
      .rclk_i    (rclk),
      .arst_i    (arst),
      .push_i    (oq_push),
      .wr_data_i (wr_entry),
      .pop_i     (grant_hit),
      .head_o    (head),
      .next_o    (next_entry),
      .cnt_o     (oq_cnt),
      .full_o    (oq_full),
      .perr_o    (oq_perr)
   );

   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         atom_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (oq_cnt != '0) begin
                  state_q <= ST_REQ;
                  req_q   <= head[8:1];
                  atom_q  <= head[0];
               end
            end
            ST_REQ: begin
               state_q <= ST_WAIT;
               req_q   <= '0;
               atom_q  <= 1'b0;
               data_q  <= head[ENTRY_W-1:9];
            end
            ST_WAIT: begin
               if (grant_hit) begin
                  data_q <= '0;
                  if (more_pkt) begin
                     state_q <= ST_REQ;
                     req_q   <= nxt_sel[8:1];
                     atom_q  <= nxt_sel[0];
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= '0;
               atom_q  <= 1'b0;
               data_q  <= '0;
            end
         endcase
      end
   end

   assign sctag_cpx_req_cq  = req_q;
   assign sctag_cpx_atom_cq = atom_q;
   assign sctag_cpx_data_ca = data_q;

endmodule

// File: doc/sctag_cpx_oq.md
SCTAG_CPX_OQ -- requirements
Module: sctag_cpx_oq

Interface
REQ-001 Parameter CPX_WIDTH, default 145: CPX packet payload width.
REQ-002 Parameter OQ_DEPTH, default 4: output-queue entries; power of two.
REQ-003 rclk  in  1  single clock; all state updates on its rising edge.
REQ-004 arst  in  1  reset, asynchronous assert, active-high.
REQ-005 oq_push  in  1  upstream packet-valid strobe.
REQ-006 oq_pkt  in  CPX_WIDTH  packet payload.
REQ-007 oq_dest  in  8  one-hot destination core.
REQ-008 oq_atom  in  1  packet is the first of an atomic pair.
REQ-009 oq_full  out  1  registered; queue holds OQ_DEPTH entries.
REQ-010 oq_cnt  out  $clog2(OQ_DEPTH)+1  registered occupancy.
REQ-011 sctag_cpx_req_cq  out  8  CPX request, one-hot, toward the CPX repeater.
REQ-012 sctag_cpx_atom_cq  out  1  atomic qualifier for sctag_cpx_req_cq.
REQ-013 sctag_cpx_data_ca  out  CPX_WIDTH  CPX packet data.
REQ-014 cpx_sctag_grant_cx  in  8  CPX grant, from the CPX repeater.

Function
REQ-015 Write: entry written at edge when oq_push=1 and oq_full=0.
REQ-016 Push while oq_full=1: dropped, no state change, flagged as protocol error; a same-cycle pop does not admit it.
REQ-017 Pointers wrap modulo OQ_DEPTH; push and pop in the same cycle leave oq_cnt unchanged.
REQ-018 FSM states: IDLE, REQ, WAIT.
REQ-019 IDLE -> REQ when oq_cnt != 0; otherwise stay.
REQ-020 REQ: sctag_cpx_req_cq = head oq_dest for exactly one cycle; next state always WAIT.
REQ-021 WAIT: sctag_cpx_data_ca = head oq_pkt every cycle up to and including the grant cycle; it is 0 in all other states.
REQ-022 Grant: in WAIT, (cpx_sctag_grant_cx & head dest) != 0 pops the head; grants with no matching bit, or outside WAIT, are ignored.
REQ-023 After a pop: go to REQ if post-pop occupancy (excluding a same-cycle push) is nonzero, else IDLE.
REQ-024 Latency: push in cycle N into an empty IDLE queue gives req in N+2, data from N+3; minimum 3 cycles per packet.
REQ-025 sctag_cpx_req_cq and sctag_cpx_atom_cq are 0 outside REQ.

Reset
REQ-026 While arst=1: FSM IDLE, pointers 0, oq_cnt 0, oq_full 0, req_cq 0, atom_cq 0, data_ca 0.
REQ-027 Reset mid-REQ or mid-WAIT discards all queued packets; a later grant has no effect.
REQ-028 Storage array contents are not reset; all reads are gated by occupancy.

Configuration
REQ-029 Macro SCTAG_CPX_OQ_ATOM_EN defined: sctag_cpx_atom_cq = head oq_atom during REQ; the grant of an atomic first packet moves the FSM directly to REQ for the second packet (upstream pushes pairs on consecutive cycles).
REQ-030 Macro undefined: sctag_cpx_atom_cq tied 0, oq_atom ignored, all packets handled as in REQ-019..023.

Structure
REQ-031 Package sctag_cpx_pkg: CPX_WIDTH, OQ_DEPTH defaults, FSM state enum, packet entry struct {pkt, dest, atom}.
REQ-032 Sub-module sctag_cpx_oq_fifo holds storage, pointers, oq_cnt and oq_full; the top holds the FSM and output muxing.

Verification
REQ-033 Single packet: push pkt=0x1A5, dest=8'h04 at cycle 0 -> req_cq=8'h04 at cycle 2; data_ca=0x1A5 from cycle 3; grant=8'h04 at cycle 5 -> oq_cnt=0, FSM IDLE at cycle 6.
REQ-034 Fill: 5 back-to-back pushes -> oq_full=1 after the 4th push; 5th dropped; queue drains 4 packets in order.
REQ-035 Wrong grant: head dest=8'h01, grant=8'h02 -> no pop, data held; then grant=8'h01 -> pop.
REQ-036 Atomic (macro defined): pair pushed with atom=1,0 -> atom_cq=1 with first req; second req the cycle after the first grant.
REQ-037 Reset in WAIT with 3 queued -> all outputs 0, oq_cnt=0; a following grant=8'hFF changes nothing.
